// File: rtl/radar_pkg.sv
// Shared definitions for the radar scan path: FSM encoding, default widths
// and constants reused by servo, sensor and VGA blocks.
package radar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_TRIG   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_NEXT   = 3'd5
  } scan_state_t;

  localparam int unsigned N_STEPS_DEF = 16;
  localparam int unsigned ANGLE_W_DEF = 4;
  localparam int unsigned DIST_W_DEF  = 16;
  localparam int unsigned CLK_HZ      = 100_000_000;

  localparam logic [DIST_W_DEF-1:0] NO_ECHO = {DIST_W_DEF{1'b1}};

endpackage

// File: rtl/sweep_angle_stepper.sv
// Holds the commanded servo angle and sweep direction; advances one
// ping-pong step per strobe, turning around at both endpoints.
module sweep_angle_stepper
  import radar_pkg::*;
#(
  parameter int unsigned N_STEPS = N_STEPS_DEF,
  parameter int unsigned ANGLE_W = ANGLE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  output logic [ANGLE_W-1:0] angle_idx,
  output logic               sweep_dir
);

  localparam logic [ANGLE_W-1:0] ANGLE_MAX = ANGLE_W'(N_STEPS - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      angle_idx <= '0;
      sweep_dir <= 1'b0;
    end else if (step) begin
      // Endpoints turn around immediately so they are measured only once.
      if (!sweep_dir && angle_idx == ANGLE_MAX) begin
        sweep_dir <= 1'b1;
        angle_idx <= ANGLE_W'(N_STEPS - 2);
      end else if (sweep_dir && angle_idx == '0) begin
        sweep_dir <= 1'b0;
        angle_idx <= ANGLE_W'(1);
      end else if (sweep_dir) begin
        angle_idx <= angle_idx - ANGLE_W'(1);
      end else begin
        angle_idx <= angle_idx + ANGLE_W'(1);
      end
    end
  end

endmodule

// File: rtl/radar_scan_sequencer.sv
// Radar sweep sequencer: settle, trigger, await echo or timeout, write the
// distance into the per-angle scan buffer, then step the servo.
//
// state  | meaning
// IDLE   | stopped, angle held, waiting for enable
// SETTLE | servo settling after an angle change
// TRIG   | one-cycle measurement start
// WAIT   | waiting for meas_done or timeout
// WRITE  | one-cycle scan-buffer write
// NEXT   | stop or advance to the next angle
module radar_scan_sequencer
  import radar_pkg::*;
#(
  parameter int unsigned N_STEPS        = N_STEPS_DEF,
  parameter int unsigned ANGLE_W        = ANGLE_W_DEF,
  parameter int unsigned DIST_W         = DIST_W_DEF,
  parameter int unsigned SETTLE_CYCLES  = 2_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 3_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  output logic [ANGLE_W-1:0] angle_idx,
  output logic               meas_start,
  input  logic               meas_done,
  input  logic [DIST_W-1:0]  meas_dist,
  output logic               wr_en,
  output logic [ANGLE_W-1:0] wr_addr,
  output logic [DIST_W-1:0]  wr_data,
  output logic               sweep_dir,
  output logic               busy,
  output logic               timeout_flag,
  output logic               frame_done
);

  localparam int unsigned MAX_CYC = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [ANGLE_W-1:0] ANGLE_MAX = ANGLE_W'(N_STEPS - 1);

  scan_state_t        state, next_state;
  logic [CNT_W-1:0]   cnt;
  logic               step;
  logic               expired;
  logic               meas_start_d, wr_en_d, busy_d, timeout_flag_d, frame_done_d;
  logic [ANGLE_W-1:0] wr_addr_d;
  logic [DIST_W-1:0]  wr_data_d;

  assign step    = (state == ST_NEXT) && enable;
  assign expired = (cnt == '0);

  sweep_angle_stepper #(
    .N_STEPS (N_STEPS),
    .ANGLE_W (ANGLE_W)
  ) u_stepper (
    .clk       (clk),
    .rst       (rst),
    .step      (step),
    .angle_idx (angle_idx),
    .sweep_dir (sweep_dir)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (enable) next_state = ST_SETTLE;
      ST_SETTLE: if (expired) next_state = ST_TRIG;
      ST_TRIG:   next_state = ST_WAIT;
      ST_WAIT:   if (meas_done || expired) next_state = ST_WRITE;
      ST_WRITE:  next_state = ST_NEXT;
      ST_NEXT:   next_state = enable ? ST_SETTLE : ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Shared down-counter: settle time, then echo timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if ((state == ST_IDLE || state == ST_NEXT) && enable) begin
      cnt <= CNT_W'(SETTLE_CYCLES);
    end else if (state == ST_TRIG) begin
      cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
    end else if ((state == ST_SETTLE || state == ST_WAIT) && !expired) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_comb begin
    meas_start_d   = (next_state == ST_TRIG);
    wr_en_d        = (next_state == ST_WRITE);
    busy_d         = (next_state != ST_IDLE);
    wr_addr_d      = wr_addr;
    wr_data_d      = wr_data;
    timeout_flag_d = timeout_flag;
    frame_done_d   = 1'b0;
    if (state == ST_IDLE && enable) timeout_flag_d = 1'b0;
    if (state == ST_WAIT) begin
      // meas_done takes priority over a coincident expiry.
      if (meas_done) begin
        wr_data_d = meas_dist;
      end else if (expired) begin
        wr_data_d      = {DIST_W{1'b1}};
        timeout_flag_d = 1'b1;
      end
    end
    if (next_state == ST_WRITE) begin
      wr_addr_d    = angle_idx;
      frame_done_d = (!sweep_dir && angle_idx == ANGLE_MAX) || (sweep_dir && angle_idx == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meas_start   <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      busy         <= 1'b0;
      timeout_flag <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      meas_start   <= meas_start_d;
      wr_en        <= wr_en_d;
      wr_addr      <= wr_addr_d;
      wr_data      <= wr_data_d;
      busy         <= busy_d;
      timeout_flag <= timeout_flag_d;
      frame_done   <= frame_done_d;
    end
  end

endmodule
